// File: rtl/clk_div_pkg.sv
// clk_div_pkg: state encoding and per-state output patterns {clk270,clk180,clk90,clk0}
`timescale 1ns/1ps
package clk_div_pkg;
   typedef enum logic [2:0] {IDLE, P0, P1, P2, P3} state_e;
   localparam logic [3:0] PAT_IDLE = 4'b0000;
   localparam logic [3:0] PAT_P0   = 4'b1001;
   localparam logic [3:0] PAT_P1   = 4'b0011;
   localparam logic [3:0] PAT_P2   = 4'b0110;
   localparam logic [3:0] PAT_P3   = 4'b1100;
   function automatic logic [3:0] out_pat(input state_e s);
      return (s == P0) ? PAT_P0 :
             (s == P1) ? PAT_P1 :
             (s == P2) ? PAT_P2 :
             (s == P3) ? PAT_P3 : PAT_IDLE;
   endfunction
endpackage

// File: rtl/clk_div.sv
// clk_div: fixed divide-by-4 clock generator producing four phases 90 degrees apart
`timescale 1ns/1ps
module clk_div
   import clk_div_pkg::*;
(
   input  logic clk_i,
   input  logic rst_i,
   output logic clk0_o,
   output logic clk90_o,
   output logic clk180_o,
   output logic clk270_o
);
   state_e     state_q, state_d;
   logic [3:0] out_q, out_d;
   always_ff @(posedge clk_i or negedge rst_i)
      if (!rst_i) state_q <= IDLE;
      else        state_q <= state_d;
   // IDLE, P3 and any illegal encoding all advance to P0
   always_comb
      state_d = (state_q == P0) ? P1 :
                (state_q == P1) ? P2 :
                (state_q == P2) ? P3 : P0;
   // outputs are registered from the next state so they line up with state_q
   always_comb out_d = out_pat(state_d);
   always_ff @(posedge clk_i or negedge rst_i)
      if (!rst_i) out_q <= PAT_IDLE;
      else        out_q <= out_d;
   assign {clk270_o, clk180_o, clk90_o, clk0_o} = out_q;
endmodule

// File: tb/tb_clk_div.sv
// tb_clk_div: scoreboard bench for the divide-by-4 quadrature clock generator
`timescale 1ns/1ps
module tb_clk_div;
   logic clk_i = 1'b0;
   logic rst_i = 1'b0;
   logic clk0_o, clk90_o, clk180_o, clk270_o;
   logic [3:0] obs;
   int vec = 0;
   int bad = 0;
   logic [3:0] exp_q[$];
   logic [3:0] pat_tbl [4] = '{4'b1001, 4'b0011, 4'b0110, 4'b1100};

   clk_div dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .clk0_o(clk0_o), .clk90_o(clk90_o), .clk180_o(clk180_o), .clk270_o(clk270_o)
   );

   assign obs = {clk270_o, clk180_o, clk90_o, clk0_o};
   always #50 clk_i = ~clk_i;

   initial begin
      #100000;
      $display("FAIL watchdog t=%0t", $time);
      $fatal(1, "timeout");
   end

   task automatic test_reset();
      rst_i = 1'b0;
      #1;
      vec++;
      if (obs !== 4'b0000) begin bad++; $display("FAIL reset_t0 obs=%b exp=0000", obs); end
      @(posedge clk_i); #1;
      vec++;
      if (obs !== 4'b0000) begin bad++; $display("FAIL reset_edge50 obs=%b exp=0000", obs); end
      #50;
      vec++;
      if (obs !== 4'b0000) begin bad++; $display("FAIL reset_t101 obs=%b exp=0000", obs); end
      #9 rst_i = 1'b1;
   endtask

   task automatic test_sequence();
      logic [3:0] e;
      for (int k = 0; k < 5; k++) exp_q.push_back(pat_tbl[k % 4]);
      for (int k = 0; k < 5; k++) begin
         @(posedge clk_i); #1;
         e = exp_q.pop_front();
         vec++;
         if (obs !== e) begin bad++; $display("FAIL seq_%0d t=%0t obs=%b exp=%b", k, $time, obs, e); end
         vec++;
         if (clk180_o !== ~clk0_o || clk270_o !== ~clk90_o || $countones(obs) != 2) begin
            bad++; $display("FAIL seq_inv_%0d obs=%b exp=complementary pairs, two high", k, obs);
         end
      end
   endtask

   task automatic test_steady();
      logic [3:0] e, p;
      time r0 [4], r1 [4], f0 [4];
      int nr [4], nf [4];
      for (int i = 0; i < 4; i++) begin r0[i] = 0; r1[i] = 0; f0[i] = 0; nr[i] = 0; nf[i] = 0; end
      repeat (5) @(posedge clk_i);
      #1 p = obs;
      for (int n = 10; n < 22; n++) exp_q.push_back(pat_tbl[n % 4]);
      for (int n = 10; n < 22; n++) begin
         @(posedge clk_i); #1;
         e = exp_q.pop_front();
         vec++;
         if (obs !== e) begin bad++; $display("FAIL steady_%0d obs=%b exp=%b", n, obs, e); end
         vec++;
         if (clk180_o !== ~clk0_o || clk270_o !== ~clk90_o || $countones(obs) != 2) begin
            bad++; $display("FAIL steady_inv_%0d obs=%b exp=complementary pairs, two high", n, obs);
         end
         for (int i = 0; i < 4; i++) begin
            if (!p[i] && obs[i]) begin
               if (nr[i] == 0) r0[i] = $time;
               else if (nr[i] == 1) r1[i] = $time;
               nr[i]++;
            end
            if (p[i] && !obs[i] && nr[i] == 1 && nf[i] == 0) begin f0[i] = $time; nf[i]++; end
         end
         p = obs;
      end
      for (int i = 0; i < 4; i++) begin
         vec++;
         if (nr[i] < 2 || r1[i] - r0[i] != 400) begin
            bad++; $display("FAIL period_%0d got=%0t exp=400", i, r1[i] - r0[i]);
         end
         vec++;
         if (nf[i] < 1 || f0[i] - r0[i] != 200) begin
            bad++; $display("FAIL high_%0d got=%0t exp=200", i, f0[i] - r0[i]);
         end
      end
      vec++;
      if (r0[1] - r0[0] != 100) begin
         bad++; $display("FAIL phase90 got=%0t exp=100", r0[1] - r0[0]);
      end
   endtask

   task automatic test_mid_reset();
      logic [3:0] e;
      rst_i = 1'b0;
      #1;
      vec++;
      if (obs !== 4'b0000) begin bad++; $display("FAIL mid_assert obs=%b exp=0000", obs); end
      @(posedge clk_i); #1;
      vec++;
      if (obs !== 4'b0000) begin bad++; $display("FAIL mid_hold obs=%b exp=0000", obs); end
      #59 rst_i = 1'b1;
      for (int k = 0; k < 3; k++) exp_q.push_back(pat_tbl[k]);
      for (int k = 0; k < 3; k++) begin
         @(posedge clk_i); #1;
         e = exp_q.pop_front();
         vec++;
         if (obs !== e) begin bad++; $display("FAIL mid_pre_%0d obs=%b exp=%b", k, obs, e); end
      end
      #19 rst_i = 1'b0;
      #1;
      vec++;
      if (obs !== 4'b0000) begin bad++; $display("FAIL mid_abort obs=%b exp=0000", obs); end
      #39 rst_i = 1'b1;
      exp_q.push_back(pat_tbl[0]);
      exp_q.push_back(pat_tbl[1]);
      for (int k = 0; k < 2; k++) begin
         @(posedge clk_i); #1;
         e = exp_q.pop_front();
         vec++;
         if (obs !== e) begin bad++; $display("FAIL mid_restart_%0d obs=%b exp=%b", k, obs, e); end
      end
   endtask

   initial begin
      test_reset();
      test_sequence();
      test_steady();
      test_mid_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
      $finish;
   end
endmodule

// File: doc/clk_div.md
CLK_DIV -- requirements
Module: clk_div

Interface
REQ-001 The block SHALL have no parameters; the divide ratio is fixed at 4.
REQ-002 clk_i  input  1  The single clock; all state advances on its rising edge.
REQ-003 rst_i  input  1  Reset, asynchronous and active-low: 0 = reset asserted, 1 = run.
REQ-004 clk0_o  output  1  Divided clock, 0-degree phase.
REQ-005 clk90_o  output  1  Divided clock, lagging clk0_o by 90 degrees (one clk_i period).
REQ-006 clk180_o  output  1  Divided clock, lagging clk0_o by 180 degrees (two clk_i periods).
REQ-007 clk270_o  output  1  Divided clock, lagging clk0_o by 270 degrees (three clk_i periods).

Function
REQ-008 The block SHALL implement a 5-state FSM: IDLE, P0, P1, P2, P3.
REQ-009 The FSM SHALL enter IDLE only via reset.
REQ-010 Transitions SHALL occur on each rising clk_i edge: IDLE->P0, P0->P1, P1->P2, P2->P3, P3->P0.
REQ-011 In IDLE all four outputs SHALL be 0.
REQ-012 In P0 the outputs SHALL be: clk0_o=1, clk90_o=0, clk180_o=0, clk270_o=1.
REQ-013 In P1 the outputs SHALL be: clk0_o=1, clk90_o=1, clk180_o=0, clk270_o=0.
REQ-014 In P2 the outputs SHALL be: clk0_o=0, clk90_o=1, clk180_o=1, clk270_o=0.
REQ-015 In P3 the outputs SHALL be: clk0_o=0, clk90_o=0, clk180_o=1, clk270_o=1.
REQ-016 Each output SHALL have a period of 4 clk_i cycles and a 50% duty cycle (2 high, 2 low).
REQ-017 Adjacent phases SHALL be offset by exactly one clk_i cycle.
REQ-018 clk180_o SHALL always equal the inverse of clk0_o, and clk270_o the inverse of clk90_o, except in IDLE.
REQ-019 Every output SHALL be driven directly by a dedicated flip-flop, with no combinational logic after the flop, so outputs are glitch-free.
REQ-020 An illegal state encoding SHALL recover to P0 on the next rising clk_i edge.
REQ-021 Latency: the first phase (P0) outputs SHALL appear at the first rising clk_i edge after rst_i goes high.

Reset
REQ-022 Asserting rst_i=0 SHALL immediately, without waiting for a clock edge, force IDLE and all outputs to 0.
REQ-023 While rst_i=0, the outputs SHALL stay 0 regardless of clk_i activity.
REQ-024 Reset asserted mid-sequence SHALL abort the sequence.
REQ-025 After such a reset is released, the sequence SHALL restart at P0; no partial phase is resumed.
REQ-026 rst_i deassertion SHALL be assumed synchronous to clk_i at system level; the block SHALL contain no internal reset synchronizer.

Structure
REQ-027 A shared package clk_div_pkg SHALL hold the state enumeration (IDLE, P0..P3).
REQ-028 clk_div_pkg SHALL also hold named constants for the per-state 4-bit output pattern {clk270,clk180,clk90,clk0}.
REQ-029 The output patterns SHALL be: P0=4'b1001, P1=4'b0011, P2=4'b0110, P3=4'b1100, IDLE=4'b0000.
REQ-030 The design SHALL be a single module, clk_div, with no sub-modules.
REQ-031 The FSM next-state logic and the output flops SHALL be kept as separate logic blocks within clk_div.

Verification (clk_i period 100 ns, first rising edge at 50 ns)
REQ-032 Bench SHALL check reset: rst_i=0 from t=0 to 110 ns, clk_i toggling -> all outputs 0 throughout, including at the 50 ns edge.
REQ-033 Bench SHALL check sequence start: rst_i=1 at 110 ns -> at the 150 ns edge pattern 1001; at 250 ns 0011; at 350 ns 0110; at 450 ns 1100; at 550 ns 1001.
REQ-034 Bench SHALL check the steady state: 10 cycles after release -> each output period = 400 ns, high time = 200 ns, clk90_o rising edges exactly 100 ns after clk0_o rising edges.
REQ-035 Bench SHALL check reset mid-operation: rst_i=0 at 370 ns (state P2) -> all outputs 0 at 370 ns, without waiting for an edge; release at 410 ns -> pattern 1001 at the 450 ns edge.
REQ-036 Bench SHALL check invariants on every edge after the first post-reset edge: clk180_o = ~clk0_o, clk270_o = ~clk90_o, and exactly two outputs high.
